// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle unsigned magnitude comparator: 3 bits per cycle, MSB chunk first, valid/ready on both sides.
// Optional SERIAL_CMP_EARLY_EXIT_EN finishes as soon as the first differing chunk is seen.
module serial_magnitude_comparator #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             busy
);

  localparam int NCHUNK = (WIDTH + 2) / 3;
  localparam int EXT    = 3 * NCHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [EXT-1:0] a_q, a_d, b_q, b_d;
  logic           lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
  logic           out_valid_q, out_valid_d;
  logic [2:0]     ca_s, cb_s;
  logic [2:0]     cmp_s;
  logic [2:0]     casc_s;
  logic           last_s;

  // Current chunk of each operand and its 3-bit lt/eq/gt compare.
  always_comb begin
    ca_s  = 3'(a_q >> (3 * cnt_q));
    cb_s  = 3'(b_q >> (3 * cnt_q));
    cmp_s = {ca_s < cb_s, ca_s == cb_s, ca_s > cb_s};
  end

  // Cascade: once a chunk differs, the decision is frozen.
  always_comb begin
    if (eq_q) begin
      casc_s = cmp_s;
    end else begin
      casc_s = {lt_q, eq_q, gt_q};
    end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    last_s = (cnt_q == '0) || !casc_s[1];
`else
    last_s = (cnt_q == '0);
`endif
  end

  // Next-state logic for the IDLE/RUN/DONE controller and datapath.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    lt_d        = lt_q;
    eq_d        = eq_q;
    gt_d        = gt_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = EXT'(a);
          b_d     = EXT'(b);
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          cnt_d   = CW'(NCHUNK - 1);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        {lt_d, eq_d, gt_d} = casc_s;
        if (last_s) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset discards any in-flight comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      gt_q        <= gt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign gt        = gt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator at WIDTH=12 and WIDTH=7, either build.
module tb_serial_magnitude_comparator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv12 = 1'b0, or12 = 1'b1;
  logic [11:0] a12 = '0, b12 = '0;
  logic        ir12, ov12, lt12, eq12, gt12, busy12;
  logic        iv7 = 1'b0, or7 = 1'b1;
  logic [6:0]  a7 = '0, b7 = '0;
  logic        ir7, ov7, lt7, eq7, gt7, busy7;

  serial_magnitude_comparator #(.WIDTH(12)) dut12 (
    .clk(clk), .rst(rst), .in_valid(iv12), .in_ready(ir12), .a(a12), .b(b12),
    .out_valid(ov12), .out_ready(or12), .lt(lt12), .eq(eq12), .gt(gt12), .busy(busy12));

  serial_magnitude_comparator #(.WIDTH(7)) dut7 (
    .clk(clk), .rst(rst), .in_valid(iv7), .in_ready(ir7), .a(a7), .b(b7),
    .out_valid(ov7), .out_ready(or7), .lt(lt7), .eq(eq7), .gt(gt7), .busy(busy7));

  logic use7 = 1'b0;
  wire m_ir   = use7 ? ir7   : ir12;
  wire m_ov   = use7 ? ov7   : ov12;
  wire m_lt   = use7 ? lt7   : lt12;
  wire m_eq   = use7 ? eq7   : eq12;
  wire m_gt   = use7 ? gt7   : gt12;
  wire m_busy = use7 ? busy7 : busy12;

  typedef struct {
    logic lt;
    logic eq;
    logic gt;
    int   lat;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  function automatic int exp_lat(input logic [11:0] x, input int nchunk);
    int h;
    if (x == 12'd0) return nchunk;
    h = 0;
    for (int i = 0; i < 12; i++) if (x[i]) h = i;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    return nchunk - h / 3;
`else
    return nchunk;
`endif
  endfunction

  task automatic accept(input logic [11:0] av, input logic [11:0] bv);
    exp_t e;
    int   w;
    w = 0;
    while (!m_ir && w < 20) begin
      @(posedge clk); #1; w++;
    end
    n_checks++;
    if (!m_ir) begin
      $display("FAIL accept_wait: in_ready=%0b required 1", m_ir);
      n_errors++;
    end
    e.lt  = av < bv;
    e.eq  = av == bv;
    e.gt  = av > bv;
    e.lat = exp_lat(av ^ bv, use7 ? 3 : 4);
    sb.push_back(e);
    if (use7) begin a7 = av[6:0]; b7 = bv[6:0]; iv7 = 1'b1; end
    else begin a12 = av; b12 = bv; iv12 = 1'b1; end
    @(posedge clk); #1;
    iv12 = 1'b0;
    iv7  = 1'b0;
  endtask

  task automatic collect(input string name);
    exp_t e;
    int   lat;
    lat = 0;
    while (!m_ov && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (!m_ov || sb.size() == 0) begin
      $display("FAIL %s_timeout: out_valid=%0b queued=%0d", name, m_ov, sb.size());
      n_errors++;
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (lat !== e.lat) begin
      $display("FAIL %s_latency: got %0d required %0d", name, lat, e.lat);
      n_errors++;
    end
    n_checks++;
    if ({m_lt, m_eq, m_gt} !== {e.lt, e.eq, e.gt}) begin
      $display("FAIL %s_result: lt/eq/gt=%b required %b", name, {m_lt, m_eq, m_gt}, {e.lt, e.eq, e.gt});
      n_errors++;
    end
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if ({ov12, lt12, eq12, gt12, busy12, ov7, busy7} !== 7'b0) begin
      $display("FAIL reset_outputs: ov/lt/eq/gt/busy/ov7/busy7=%b required 0000000",
               {ov12, lt12, eq12, gt12, busy12, ov7, busy7});
      n_errors++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({ir12, busy12} !== 2'b10) begin
      $display("FAIL reset_release: in_ready/busy=%b required 10", {ir12, busy12});
      n_errors++;
    end
  endtask

  task automatic test_equal;
    accept(12'hABC, 12'hABC);
    collect("equal");
    @(posedge clk); #1;
    n_checks++;
    if ({m_ir, m_ov, m_eq} !== 3'b101) begin
      $display("FAIL equal_consume: in_ready/out_valid/eq=%b required 101", {m_ir, m_ov, m_eq});
      n_errors++;
    end
  endtask

  task automatic test_gt_msb;
    accept(12'h800, 12'h7FF);
    collect("gt_msb");
  endtask

  task automatic test_lt_operand_change;
    accept(12'h001, 12'h002);
    a12 = 12'hFFF;
    b12 = 12'hFFF;
    collect("lt_change");
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    accept(12'h5A5, 12'h5A4);
    collect("b2b_0");
    accept(12'h00F, 12'h0F0);
    collect("b2b_1");
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic [2:0] held;
    or12 = 1'b0;
    accept(12'h3C0, 12'h3C7);
    collect("bp");
    held = {m_lt, m_eq, m_gt};
    for (int i = 0; i < 5; i++) begin
      a12 = 12'($urandom); b12 = 12'($urandom); iv12 = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({m_ov, m_ir, m_lt, m_eq, m_gt} !== {2'b10, held}) begin
        $display("FAIL bp_hold: ov/ir/lt/eq/gt=%b required %b", {m_ov, m_ir, m_lt, m_eq, m_gt}, {2'b10, held});
        n_errors++;
      end
    end
    iv12 = 1'b0;
    or12 = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({m_ov, m_ir, m_busy, m_lt, m_eq, m_gt} !== {3'b010, held}) begin
      $display("FAIL bp_release: ov/ir/busy/lt/eq/gt=%b required %b",
               {m_ov, m_ir, m_busy, m_lt, m_eq, m_gt}, {3'b010, held});
      n_errors++;
    end
  endtask

  task automatic test_reset_mid_op;
    accept(12'h9F0, 12'h9F0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({m_ov, m_lt, m_eq, m_gt, m_busy} !== 5'b0) begin
      $display("FAIL reset_mid: ov/lt/eq/gt/busy=%b required 00000", {m_ov, m_lt, m_eq, m_gt, m_busy});
      n_errors++;
    end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    accept(12'h123, 12'h124);
    collect("after_reset");
    @(posedge clk); #1;
  endtask

  task automatic test_width7;
    use7 = 1'b1;
    accept(12'h040, 12'h03F);
    collect("w7_gt");
    @(posedge clk); #1;
    accept(12'h07F, 12'h07F);
    collect("w7_eq");
    @(posedge clk); #1;
    use7 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_equal();
    test_gt_msb();
    test_lt_operand_change();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    test_width7();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
